// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the arbitrated paged-memory bus.
package mem_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    typedef enum logic {OP_READ, OP_WRITE} op_t;

    localparam int unsigned DEF_DATA_W        = 32;
    localparam int unsigned DEF_ADDR_W        = 32;
    localparam int unsigned DEF_OFFSET_W      = 6;
    localparam int unsigned DEF_PAGE_W        = 4;
    localparam int unsigned DEF_NUM_MASTERS   = 2;
    localparam int unsigned DEF_MEM_LATENCY   = 1;
    localparam int unsigned DEF_FINISH_OFFSET = 60;

endpackage

// File: rtl/bus_arbiter_core.sv
// Request arbiter: fixed priority (highest index wins), or round-robin when
// BUS_RR_ARB_EN is defined.
module bus_arbiter_core
    import mem_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
`ifdef BUS_RR_ARB_EN
    input  logic                           clk,
    input  logic                           reset,
`endif
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           grant_en,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    logic found;

`ifdef BUS_RR_ARB_EN
    logic [IDX_W-1:0] last_q;
    int unsigned      cand;

    // Search starts just past the last granted master and wraps around.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = (32'(last_q) + k) % NUM_MASTERS;
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else if (grant_en && found) begin
            last_q <= grant_idx;
        end
    end
`else
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (req[i]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master arbitrated front end for the single-port paged test memory with a
// sticky finish flag. Define BUS_RR_ARB_EN for round-robin arbitration.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned OFFSET_W      = DEF_OFFSET_W,
    parameter int unsigned PAGE_W        = DEF_PAGE_W,
    parameter int unsigned NUM_MASTERS   = DEF_NUM_MASTERS,
    parameter int unsigned MEM_LATENCY   = DEF_MEM_LATENCY,
    parameter int unsigned FINISH_OFFSET = DEF_FINISH_OFFSET
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PAGE_W-1:0]               memory_page_number,
    input  logic                            finish_clear,
    output logic                            finish,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_write_data,
    output logic [DATA_W-1:0]               m_read_data,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_id,
    output logic                            busy,
    output logic                            memory_read,
    output logic                            memory_write,
    output logic [ADDR_W-1:0]               memory_address,
    output logic [DATA_W-1:0]               memory_write_data,
    input  logic [DATA_W-1:0]               memory_read_data
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [OFFSET_W-1:0] FIN_OFF = OFFSET_W'(FINISH_OFFSET);

    state_t                  state;
    op_t                     op;
    logic [OFFSET_W-1:0]     offset_q;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_MASTERS-1:0]  req;
    logic [NUM_MASTERS-1:0]  grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_en;
    logic                    is_write;
    logic [OFFSET_W-1:0]     sel_offset;
    logic [DATA_W-1:0]       sel_wdata;
    logic [ADDR_W-1:0]       next_addr;
    logic                    unused_addr_bits;

    assign req        = m_read | m_write;
    assign grant_en   = (state == IDLE);
    assign is_write   = |(grant & m_write);
    assign sel_offset = m_address[grant_idx*ADDR_W +: OFFSET_W];
    assign sel_wdata  = m_write_data[grant_idx*DATA_W +: DATA_W];
    assign busy       = (state != IDLE);

    bus_arbiter_core #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_arb (
`ifdef BUS_RR_ARB_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .req       (req),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Page sits directly above the offset; anything higher is forced to zero.
    always_comb begin
        next_addr                      = '0;
        next_addr[OFFSET_W +: PAGE_W]  = memory_page_number;
        next_addr[OFFSET_W-1:0]        = sel_offset;
    end

    // Master address bits above the offset are replaced by the page.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            unused_addr_bits ^= ^m_address[i*ADDR_W+OFFSET_W +: ADDR_W-OFFSET_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            op                <= OP_READ;
            offset_q          <= '0;
            cnt               <= '0;
            finish            <= 1'b0;
            m_read_data       <= '0;
            m_ack             <= '0;
            grant_id          <= '0;
            memory_read       <= 1'b0;
            memory_write      <= 1'b0;
            memory_address    <= '0;
            memory_write_data <= '0;
        end else begin
            m_ack <= '0;
            if (finish_clear) begin
                finish <= 1'b0;
            end else if (state == ACCESS && op == OP_WRITE && offset_q == FIN_OFF) begin
                finish <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id          <= grant_idx;
                        op                <= is_write ? OP_WRITE : OP_READ;
                        offset_q          <= sel_offset;
                        memory_address    <= next_addr;
                        memory_write_data <= sel_wdata;
                        memory_read       <= !is_write;
                        memory_write      <= is_write;
                        state             <= ACCESS;
                    end
                end
                ACCESS: begin
                    memory_read  <= 1'b0;
                    memory_write <= 1'b0;
                    cnt          <= CNT_W'(MEM_LATENCY);
                    state        <= WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        if (op == OP_READ) begin
                            m_read_data <= memory_read_data;
                        end
                        m_ack[grant_id] <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: d1 runs with MEM_LATENCY=1, d2 with MEM_LATENCY=2; both share stimulus.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  page;
    logic        finish_clear;
    logic [1:0]  m_read;
    logic [1:0]  m_write;
    logic [63:0] m_address;
    logic [63:0] m_write_data;

    logic        d1_finish, d2_finish;
    logic [31:0] d1_m_read_data, d2_m_read_data;
    logic [1:0]  d1_m_ack, d2_m_ack;
    logic        d1_grant_id, d2_grant_id;
    logic        d1_busy, d2_busy;
    logic        d1_memory_read, d2_memory_read;
    logic        d1_memory_write, d2_memory_write;
    logic [31:0] d1_memory_address, d2_memory_address;
    logic [31:0] d1_memory_write_data, d2_memory_write_data;
    logic [31:0] d1_rdata, d2_rdata;

    logic [31:0] p2_data;
    logic        p2_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MEM_LATENCY(1)) d1 (
        .clk               (clk),
        .reset             (reset),
        .memory_page_number(page),
        .finish_clear      (finish_clear),
        .finish            (d1_finish),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_address         (m_address),
        .m_write_data      (m_write_data),
        .m_read_data       (d1_m_read_data),
        .m_ack             (d1_m_ack),
        .grant_id          (d1_grant_id),
        .busy              (d1_busy),
        .memory_read       (d1_memory_read),
        .memory_write      (d1_memory_write),
        .memory_address    (d1_memory_address),
        .memory_write_data (d1_memory_write_data),
        .memory_read_data  (d1_rdata)
    );

    mem_bus_arbiter #(.MEM_LATENCY(2)) d2 (
        .clk               (clk),
        .reset             (reset),
        .memory_page_number(page),
        .finish_clear      (finish_clear),
        .finish            (d2_finish),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_address         (m_address),
        .m_write_data      (m_write_data),
        .m_read_data       (d2_m_read_data),
        .m_ack             (d2_m_ack),
        .grant_id          (d2_grant_id),
        .busy              (d2_busy),
        .memory_read       (d2_memory_read),
        .memory_write      (d2_memory_write),
        .memory_address    (d2_memory_address),
        .memory_write_data (d2_memory_write_data),
        .memory_read_data  (d2_rdata)
    );

    // Memory models: data = {CAFE, addr[15:0]} exactly LATENCY cycles after the strobe,
    // DEADBEEF at every other time.
    always @(posedge clk) begin
        d1_rdata <= d1_memory_read ? {16'hCAFE, d1_memory_address[15:0]} : 32'hDEAD_BEEF;
        p2_valid <= d2_memory_read;
        p2_data  <= {16'hCAFE, d2_memory_address[15:0]};
        d2_rdata <= p2_valid ? p2_data : 32'hDEAD_BEEF;
    end

    task automatic apply_reset();
        reset = 1'b1;
        m_read = '0;
        m_write = '0;
        m_address = '0;
        m_write_data = '0;
        page = '0;
        finish_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({d1_finish, d1_m_read_data, d1_m_ack, d1_grant_id, d1_busy, d1_memory_read,
             d1_memory_write, d1_memory_address, d1_memory_write_data} !== 103'd0) begin
            errors++;
            $display("FAIL reset_d1: outputs not all zero (busy=%b ack=%b)", d1_busy, d1_m_ack);
        end
        checks++;
        if ({d2_finish, d2_m_read_data, d2_m_ack, d2_grant_id, d2_busy, d2_memory_read,
             d2_memory_write, d2_memory_address, d2_memory_write_data} !== 103'd0) begin
            errors++;
            $display("FAIL reset_d2: outputs not all zero (busy=%b ack=%b)", d2_busy, d2_m_ack);
        end
        @(negedge clk);
        checks++;
        if (d1_busy !== 1'b0 || d1_memory_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rd=%b, required 0 0", d1_busy, d1_memory_read);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        page = 4'd3;
        m_address[31:0] = 32'hABCD_0005;
        m_read[0] = 1'b1;
        @(negedge clk);  // T+1
        checks++;
        if (d2_memory_read !== 1'b1 || d2_memory_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_strobe: rd=%b wr=%b, required 1 0", d2_memory_read, d2_memory_write);
        end
        checks++;
        if (d2_memory_address !== 32'h0000_00C5) begin
            errors++;
            $display("FAIL rd_addr: got %h, required 000000c5", d2_memory_address);
        end
        @(negedge clk);  // T+2
        checks++;
        if (d2_memory_read !== 1'b0 || d2_busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_strobe_len: rd=%b busy=%b, required 0 1", d2_memory_read, d2_busy);
        end
        @(negedge clk);  // T+3
        checks++;
        if (d2_m_ack !== 2'b00) begin
            errors++;
            $display("FAIL rd_early_ack: got %b, required 00", d2_m_ack);
        end
        @(negedge clk);  // T+4
        checks++;
        if (d2_m_ack !== 2'b01) begin
            errors++;
            $display("FAIL rd_ack: got %b, required 01", d2_m_ack);
        end
        checks++;
        if (d2_m_read_data !== 32'hCAFE_00C5) begin
            errors++;
            $display("FAIL rd_data: got %h, required cafe00c5", d2_m_read_data);
        end
        m_read = '0;
        @(negedge clk);
        checks++;
        if (d2_m_ack !== 2'b00 || d2_busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: ack=%b busy=%b, required 00 0", d2_m_ack, d2_busy);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        page = 4'd1;
        m_address = {32'h0000_0014, 32'h0000_000A};
        m_write_data = {32'h1111_2222, 32'h3333_4444};
        m_read[0] = 1'b1;
        m_write[1] = 1'b1;
        @(negedge clk);  // T+1
        checks++;
        if (d1_grant_id !== 1'b1 || d1_memory_write !== 1'b1 || d1_memory_read !== 1'b0) begin
            errors++;
            $display("FAIL cont_first: gid=%b wr=%b rd=%b, required 1 1 0",
                     d1_grant_id, d1_memory_write, d1_memory_read);
        end
        checks++;
        if (d1_memory_address !== 32'h54 || d1_memory_write_data !== 32'h1111_2222) begin
            errors++;
            $display("FAIL cont_wr_bus: addr=%h data=%h, required 54 11112222",
                     d1_memory_address, d1_memory_write_data);
        end
        @(negedge clk);
        @(negedge clk);  // T+3
        checks++;
        if (d1_m_ack !== 2'b10) begin
            errors++;
            $display("FAIL cont_ack1: got %b, required 10", d1_m_ack);
        end
        m_write = '0;
        @(negedge clk);  // T+4
        checks++;
        if (d1_m_ack !== 2'b00 || d1_busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_gap: ack=%b busy=%b, required 00 0", d1_m_ack, d1_busy);
        end
        @(negedge clk);  // T+5
        checks++;
        if (d1_grant_id !== 1'b0 || d1_memory_read !== 1'b1 || d1_memory_address !== 32'h4A) begin
            errors++;
            $display("FAIL cont_second: gid=%b rd=%b addr=%h, required 0 1 4a",
                     d1_grant_id, d1_memory_read, d1_memory_address);
        end
        @(negedge clk);
        @(negedge clk);  // T+7
        checks++;
        if (d1_m_ack !== 2'b01 || d1_m_read_data !== 32'hCAFE_004A) begin
            errors++;
            $display("FAIL cont_ack0: ack=%b data=%h, required 01 cafe004a",
                     d1_m_ack, d1_m_read_data);
        end
        m_read = '0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        m_address[31:0] = 32'h0000_0009;
        m_read[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);  // T+3
        checks++;
        if (d1_m_ack !== 2'b01) begin
            errors++;
            $display("FAIL b2b_ack1: got %b, required 01", d1_m_ack);
        end
        @(negedge clk);  // T+4
        checks++;
        if (d1_busy !== 1'b0 || d1_memory_read !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b rd=%b, required 0 0", d1_busy, d1_memory_read);
        end
        @(negedge clk);  // T+5
        checks++;
        if (d1_memory_read !== 1'b1) begin
            errors++;
            $display("FAIL b2b_strobe2: got %b, required 1", d1_memory_read);
        end
        @(negedge clk);
        @(negedge clk);  // T+7
        checks++;
        if (d1_m_ack !== 2'b01) begin
            errors++;
            $display("FAIL b2b_ack2: got %b, required 01", d1_m_ack);
        end
        m_read = '0;
    endtask

    task automatic test_finish();
        apply_reset();
        m_address = {32'h0000_003C, 32'h0000_003C};
        m_write_data = {32'h0000_0005, 32'h0};
        m_write[1] = 1'b1;
        @(negedge clk);  // ACCESS
        checks++;
        if (d1_finish !== 1'b0 || d1_memory_write !== 1'b1) begin
            errors++;
            $display("FAIL fin_access: fin=%b wr=%b, required 0 1", d1_finish, d1_memory_write);
        end
        @(negedge clk);
        checks++;
        if (d1_finish !== 1'b1) begin
            errors++;
            $display("FAIL fin_set: got %b, required 1", d1_finish);
        end
        @(negedge clk);  // DONE
        m_write = '0;
        @(negedge clk);
        checks++;
        if (d1_finish !== 1'b1) begin
            errors++;
            $display("FAIL fin_sticky: got %b, required 1", d1_finish);
        end
        finish_clear = 1'b1;
        @(negedge clk);
        finish_clear = 1'b0;
        checks++;
        if (d1_finish !== 1'b0) begin
            errors++;
            $display("FAIL fin_clear: got %b, required 0", d1_finish);
        end
        m_read[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);  // DONE of the read
        checks++;
        if (d1_finish !== 1'b0 || d1_m_ack !== 2'b01) begin
            errors++;
            $display("FAIL fin_read: fin=%b ack=%b, required 0 01", d1_finish, d1_m_ack);
        end
        m_read = '0;
        @(negedge clk);
        m_write[1] = 1'b1;
        @(negedge clk);  // ACCESS of a finishing write
        finish_clear = 1'b1;
        @(negedge clk);
        finish_clear = 1'b0;
        checks++;
        if (d1_finish !== 1'b0) begin
            errors++;
            $display("FAIL fin_clear_wins: got %b, required 0", d1_finish);
        end
        @(negedge clk);
        m_write = '0;
        checks++;
        if (d1_finish !== 1'b0) begin
            errors++;
            $display("FAIL fin_clear_hold: got %b, required 0", d1_finish);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        page = 4'd2;
        m_address[63:32] = 32'h0000_0007;
        m_read[1] = 1'b1;
        @(negedge clk);  // ACCESS
        checks++;
        if (d2_memory_read !== 1'b1 || d2_grant_id !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_access: rd=%b gid=%b, required 1 1", d2_memory_read, d2_grant_id);
        end
        @(negedge clk);  // WAIT
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({d2_finish, d2_m_read_data, d2_m_ack, d2_grant_id, d2_busy, d2_memory_read,
             d2_memory_write, d2_memory_address, d2_memory_write_data} !== 103'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b gid=%b addr=%h, required all 0",
                     d2_busy, d2_grant_id, d2_memory_address);
        end
        reset = 1'b0;
        m_read = '0;
        @(negedge clk);  // where the aborted ack would have been
        checks++;
        if (d2_m_ack !== 2'b00 || d2_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_noack: ack=%b busy=%b, required 00 0", d2_m_ack, d2_busy);
        end
        @(negedge clk);
        checks++;
        if (d2_m_ack !== 2'b00 || d2_memory_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: ack=%b rd=%b, required 00 0", d2_m_ack, d2_memory_read);
        end
    endtask

    task automatic test_dropped_request();
        int acks;
        int strobes;
        apply_reset();
        acks = 0;
        strobes = 0;
        m_address[31:0] = 32'h0000_0003;
        m_read[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) m_read = '0;
            acks += int'(d1_m_ack[0]);
            strobes += int'(d1_memory_read);
            if (k == 3) begin
                checks++;
                if (d1_m_ack !== 2'b01) begin
                    errors++;
                    $display("FAIL drop_ack_time: got %b, required 01", d1_m_ack);
                end
            end
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL drop_ack_count: got %0d, required 1", acks);
        end
        checks++;
        if (strobes !== 1) begin
            errors++;
            $display("FAIL drop_strobe_count: got %0d, required 1", strobes);
        end
        checks++;
        if (d1_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: busy=%b, required 0", d1_busy);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_order;
`ifdef BUS_RR_ARB_EN
        exp_order = 4'b0101;  // grants 1,0,1,0 (bit t = transaction t)
`else
        exp_order = 4'b1111;  // highest index always wins
`endif
        apply_reset();
        m_address = {32'h0000_0002, 32'h0000_0001};
        m_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            checks++;
            if (d1_memory_read !== 1'b1 || d1_grant_id !== exp_order[t]) begin
                errors++;
                $display("FAIL arb_order[%0d]: rd=%b gid=%b, required 1 %b",
                         t, d1_memory_read, d1_grant_id, exp_order[t]);
            end
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
        end
        m_read = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_finish();
        test_reset_mid_wait();
        test_dropped_request();
        test_arbitration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
